// File: rtl/axi_mem_arb_pkg.sv
// rtl/axi_mem_arb_pkg.sv - shared types and constants for the two-master AXI memory arbiter
package axi_mem_arb_pkg;

   localparam int NUM_MST = 2;

   typedef enum logic [1:0] {
      WR_IDLE = 2'd0,
      WR_ADDR = 2'd1,
      WR_DATA = 2'd2,
      WR_RESP = 2'd3
   } wr_state_t;

   typedef enum logic [1:0] {
      RD_IDLE = 2'd0,
      RD_ADDR = 2'd1,
      RD_DATA = 2'd2
   } rd_state_t;

endpackage

// File: rtl/axi_arb_rr2.sv
// rtl/axi_arb_rr2.sv - two-way round-robin picker returning the winning master index
module axi_arb_rr2
   import axi_mem_arb_pkg::*;
(
   input  logic [NUM_MST-1:0] req_i,
   input  logic               last_i,
   output logic               gnt_o
);

   // A lone requester wins; on a tie the master that was not served last wins.
   always_comb begin
      gnt_o = 1'b0;
      case (req_i)
         2'b01:   gnt_o = 1'b0;
         2'b10:   gnt_o = 1'b1;
         2'b11:   gnt_o = ~last_i;
         default: gnt_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/axi_mem_arbiter.sv
// rtl/axi_mem_arbiter.sv - 2:1 AXI4 arbiter onto the DDR port; optional burst counters via AXI_MEM_ARB_PERF_EN
module axi_mem_arbiter
   import axi_mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64,
   parameter int ID_W   = 6
) (
   input  logic                             clk,
   input  logic                             rst,
   // write address, per master
   input  logic [NUM_MST-1:0][ID_W-1:0]     s_awid,
   input  logic [NUM_MST-1:0][ADDR_W-1:0]   s_awaddr,
   input  logic [NUM_MST-1:0][7:0]          s_awlen,
   input  logic [NUM_MST-1:0][2:0]          s_awsize,
   input  logic [NUM_MST-1:0][1:0]          s_awburst,
   input  logic [NUM_MST-1:0]               s_awvalid,
   output logic [NUM_MST-1:0]               s_awready,
   // write data, per master
   input  logic [NUM_MST-1:0][DATA_W-1:0]   s_wdata,
   input  logic [NUM_MST-1:0][DATA_W/8-1:0] s_wstrb,
   input  logic [NUM_MST-1:0]               s_wlast,
   input  logic [NUM_MST-1:0]               s_wvalid,
   output logic [NUM_MST-1:0]               s_wready,
   // write response, per master
   output logic [NUM_MST-1:0][ID_W-1:0]     s_bid,
   output logic [NUM_MST-1:0][1:0]          s_bresp,
   output logic [NUM_MST-1:0]               s_bvalid,
   input  logic [NUM_MST-1:0]               s_bready,
   // read address, per master
   input  logic [NUM_MST-1:0][ID_W-1:0]     s_arid,
   input  logic [NUM_MST-1:0][ADDR_W-1:0]   s_araddr,
   input  logic [NUM_MST-1:0][7:0]          s_arlen,
   input  logic [NUM_MST-1:0][2:0]          s_arsize,
   input  logic [NUM_MST-1:0][1:0]          s_arburst,
   input  logic [NUM_MST-1:0]               s_arvalid,
   output logic [NUM_MST-1:0]               s_arready,
   // read data, per master
   output logic [NUM_MST-1:0][ID_W-1:0]     s_rid,
   output logic [NUM_MST-1:0][DATA_W-1:0]   s_rdata,
   output logic [NUM_MST-1:0][1:0]          s_rresp,
   output logic [NUM_MST-1:0]               s_rlast,
   output logic [NUM_MST-1:0]               s_rvalid,
   input  logic [NUM_MST-1:0]               s_rready,
   // memory-side AXI bus
   output logic [ID_W-1:0]                  m_awid,
   output logic [ADDR_W-1:0]                m_awaddr,
   output logic [7:0]                       m_awlen,
   output logic [2:0]                       m_awsize,
   output logic [1:0]                       m_awburst,
   output logic                             m_awvalid,
   input  logic                             m_awready,
   output logic [DATA_W-1:0]                m_wdata,
   output logic [DATA_W/8-1:0]              m_wstrb,
   output logic                             m_wlast,
   output logic                             m_wvalid,
   input  logic                             m_wready,
   input  logic [ID_W-1:0]                  m_bid,
   input  logic [1:0]                       m_bresp,
   input  logic                             m_bvalid,
   output logic                             m_bready,
   output logic [ID_W-1:0]                  m_arid,
   output logic [ADDR_W-1:0]                m_araddr,
   output logic [7:0]                       m_arlen,
   output logic [2:0]                       m_arsize,
   output logic [1:0]                       m_arburst,
   output logic                             m_arvalid,
   input  logic                             m_arready,
   input  logic [ID_W-1:0]                  m_rid,
   input  logic [DATA_W-1:0]                m_rdata,
   input  logic [1:0]                       m_rresp,
   input  logic                             m_rlast,
   input  logic                             m_rvalid,
   output logic                             m_rready
`ifdef AXI_MEM_ARB_PERF_EN
   ,
   output logic [NUM_MST-1:0][31:0]         o_wr_bursts,
   output logic [NUM_MST-1:0][31:0]         o_rd_bursts
`endif
);

   wr_state_t wr_state_q, wr_state_d;
   rd_state_t rd_state_q, rd_state_d;
   logic      wsel_q, wsel_d;
   logic      rsel_q, rsel_d;
   logic      last_w_q, last_w_d;
   logic      last_r_q, last_r_d;
   logic      wr_gnt;
   logic      rd_gnt;

   axi_arb_rr2 u_wr_rr (
      .req_i  (s_awvalid),
      .last_i (last_w_q),
      .gnt_o  (wr_gnt)
   );

   axi_arb_rr2 u_rd_rr (
      .req_i  (s_arvalid),
      .last_i (last_r_q),
      .gnt_o  (rd_gnt)
   );

   // State, selection and round-robin history; pointers reset to 1 so master 0 wins first.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_state_q <= WR_IDLE;
         rd_state_q <= RD_IDLE;
         wsel_q     <= 1'b0;
         rsel_q     <= 1'b0;
         last_w_q   <= 1'b1;
         last_r_q   <= 1'b1;
      end else begin
         wr_state_q <= wr_state_d;
         rd_state_q <= rd_state_d;
         wsel_q     <= wsel_d;
         rsel_q     <= rsel_d;
         last_w_q   <= last_w_d;
         last_r_q   <= last_r_d;
      end
   end

   // Write path: grant in idle, then route AW, W and B to/from the selected master only.
   always_comb begin
      wr_state_d = wr_state_q;
      wsel_d     = wsel_q;
      last_w_d   = last_w_q;
      m_awid     = '0;
      m_awaddr   = '0;
      m_awlen    = '0;
      m_awsize   = '0;
      m_awburst  = '0;
      m_awvalid  = 1'b0;
      s_awready  = '0;
      m_wdata    = '0;
      m_wstrb    = '0;
      m_wlast    = 1'b0;
      m_wvalid   = 1'b0;
      s_wready   = '0;
      s_bid      = '0;
      s_bresp    = '0;
      s_bvalid   = '0;
      m_bready   = 1'b0;
      case (wr_state_q)
         WR_IDLE: begin
            if (|s_awvalid) begin
               wsel_d     = wr_gnt;
               wr_state_d = WR_ADDR;
            end
         end
         WR_ADDR: begin
            m_awid            = s_awid[wsel_q];
            m_awaddr          = s_awaddr[wsel_q];
            m_awlen           = s_awlen[wsel_q];
            m_awsize          = s_awsize[wsel_q];
            m_awburst         = s_awburst[wsel_q];
            m_awvalid         = s_awvalid[wsel_q];
            s_awready[wsel_q] = m_awready;
            if (m_awvalid && m_awready) begin
               wr_state_d = WR_DATA;
            end
         end
         WR_DATA: begin
            m_wdata          = s_wdata[wsel_q];
            m_wstrb          = s_wstrb[wsel_q];
            m_wlast          = s_wlast[wsel_q];
            m_wvalid         = s_wvalid[wsel_q];
            s_wready[wsel_q] = m_wready;
            if (m_wvalid && m_wready && m_wlast) begin
               wr_state_d = WR_RESP;
            end
         end
         WR_RESP: begin
            s_bid[wsel_q]    = m_bid;
            s_bresp[wsel_q]  = m_bresp;
            s_bvalid[wsel_q] = m_bvalid;
            m_bready         = s_bready[wsel_q];
            if (m_bvalid && m_bready) begin
               last_w_d   = wsel_q;
               wr_state_d = WR_IDLE;
            end
         end
         default: wr_state_d = WR_IDLE;
      endcase
   end

   // Read path: grant in idle, route AR to memory and R beats back to the selected master.
   always_comb begin
      rd_state_d = rd_state_q;
      rsel_d     = rsel_q;
      last_r_d   = last_r_q;
      m_arid     = '0;
      m_araddr   = '0;
      m_arlen    = '0;
      m_arsize   = '0;
      m_arburst  = '0;
      m_arvalid  = 1'b0;
      s_arready  = '0;
      s_rid      = '0;
      s_rdata    = '0;
      s_rresp    = '0;
      s_rlast    = '0;
      s_rvalid   = '0;
      m_rready   = 1'b0;
      case (rd_state_q)
         RD_IDLE: begin
            if (|s_arvalid) begin
               rsel_d     = rd_gnt;
               rd_state_d = RD_ADDR;
            end
         end
         RD_ADDR: begin
            m_arid            = s_arid[rsel_q];
            m_araddr          = s_araddr[rsel_q];
            m_arlen           = s_arlen[rsel_q];
            m_arsize          = s_arsize[rsel_q];
            m_arburst         = s_arburst[rsel_q];
            m_arvalid         = s_arvalid[rsel_q];
            s_arready[rsel_q] = m_arready;
            if (m_arvalid && m_arready) begin
               rd_state_d = RD_DATA;
            end
         end
         RD_DATA: begin
            s_rid[rsel_q]    = m_rid;
            s_rdata[rsel_q]  = m_rdata;
            s_rresp[rsel_q]  = m_rresp;
            s_rlast[rsel_q]  = m_rlast;
            s_rvalid[rsel_q] = m_rvalid;
            m_rready         = s_rready[rsel_q];
            if (m_rvalid && m_rready && m_rlast) begin
               last_r_d   = rsel_q;
               rd_state_d = RD_IDLE;
            end
         end
         default: rd_state_d = RD_IDLE;
      endcase
   end

`ifdef AXI_MEM_ARB_PERF_EN
   logic [NUM_MST-1:0][31:0] wr_cnt_q;
   logic [NUM_MST-1:0][31:0] rd_cnt_q;

   // Completed-burst counters per master: B handshake for writes, final R handshake for reads.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
      end else begin
         if (wr_state_q == WR_RESP && m_bvalid && m_bready) begin
            wr_cnt_q[wsel_q] <= wr_cnt_q[wsel_q] + 32'd1;
         end
         if (rd_state_q == RD_DATA && m_rvalid && m_rready && m_rlast) begin
            rd_cnt_q[rsel_q] <= rd_cnt_q[rsel_q] + 32'd1;
         end
      end
   end

   assign o_wr_bursts = wr_cnt_q;
   assign o_rd_bursts = rd_cnt_q;
`endif

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// tb/tb_axi_mem_arbiter.sv - directed self-checking bench for axi_mem_arbiter (AXI_MEM_ARB_PERF_EN optional)
module tb_axi_mem_arbiter;

   logic              clk = 1'b0;
   logic              rst;
   logic [1:0][5:0]   s_awid, s_arid, s_bid, s_rid;
   logic [1:0][31:0]  s_awaddr, s_araddr;
   logic [1:0][7:0]   s_awlen, s_arlen;
   logic [1:0][2:0]   s_awsize, s_arsize;
   logic [1:0][1:0]   s_awburst, s_arburst, s_bresp, s_rresp;
   logic [1:0]        s_awvalid, s_awready, s_arvalid, s_arready;
   logic [1:0][63:0]  s_wdata, s_rdata;
   logic [1:0][7:0]   s_wstrb;
   logic [1:0]        s_wlast, s_wvalid, s_wready;
   logic [1:0]        s_bvalid, s_bready;
   logic [1:0]        s_rlast, s_rvalid, s_rready;
   logic [5:0]        m_awid, m_arid, m_bid, m_rid;
   logic [31:0]       m_awaddr, m_araddr;
   logic [7:0]        m_awlen, m_arlen;
   logic [2:0]        m_awsize, m_arsize;
   logic [1:0]        m_awburst, m_arburst, m_bresp, m_rresp;
   logic              m_awvalid, m_awready, m_arvalid, m_arready;
   logic [63:0]       m_wdata, m_rdata;
   logic [7:0]        m_wstrb;
   logic              m_wlast, m_wvalid, m_wready;
   logic              m_bvalid, m_bready;
   logic              m_rlast, m_rvalid, m_rready;
`ifdef AXI_MEM_ARB_PERF_EN
   logic [1:0][31:0]  o_wr_bursts, o_rd_bursts;
`endif

   int checks = 0;
   int errors = 0;

   axi_mem_arbiter dut (
      .clk(clk), .rst(rst),
      .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
      .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
      .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
      .s_rvalid(s_rvalid), .s_rready(s_rready),
      .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
      .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
      .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
      .m_rvalid(m_rvalid), .m_rready(m_rready)
`ifdef AXI_MEM_ARB_PERF_EN
      , .o_wr_bursts(o_wr_bursts), .o_rd_bursts(o_rd_bursts)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

`ifdef AXI_MEM_ARB_PERF_EN
   task automatic single_write(input int m);
      s_awvalid = (m == 0) ? 2'b01 : 2'b10;
      s_awlen   = '0;
      m_awready = 1'b1;
      tick();
      tick();
      s_awvalid = '0;
      s_wvalid  = (m == 0) ? 2'b01 : 2'b10;
      s_wlast   = 2'b11;
      m_wready  = 1'b1;
      tick();
      s_wvalid  = '0;
      m_bvalid  = 1'b1;
      s_bready  = 2'b11;
      tick();
      m_bvalid  = 1'b0;
      tick();
   endtask

   task automatic single_read(input int m);
      s_arvalid = (m == 0) ? 2'b01 : 2'b10;
      s_arlen   = '0;
      m_arready = 1'b1;
      tick();
      tick();
      s_arvalid = '0;
      m_rvalid  = 1'b1;
      m_rlast   = 1'b1;
      s_rready  = 2'b11;
      tick();
      m_rvalid  = 1'b0;
      m_rlast   = 1'b0;
      tick();
   endtask
`endif

   initial begin
      logic [1:0]  oh;
      int          e;
      int          wi, ri, wn, rn, cyc;
      logic [63:0] wgot [8];
      logic [63:0] rgot [8];
      logic        stray;

      rst = 1'b1;
      s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0; s_awvalid = '0;
      s_wdata = '0; s_wstrb = '1; s_wlast = '0; s_wvalid = '0; s_bready = '0;
      s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0; s_arvalid = '0;
      s_rready = '0;
      m_awready = 1'b0; m_wready = 1'b0; m_bid = '0; m_bresp = '0; m_bvalid = 1'b0;
      m_arready = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;

      tick();
      tick();
      check("rst_awready", s_awready, 2'b00);
      check("rst_awvalid", m_awvalid, 1'b0);
      check("rst_arvalid", m_arvalid, 1'b0);
      check("rst_bvalid", s_bvalid, 2'b00);
      check("rst_awaddr", m_awaddr, 32'h0);
      rst = 1'b0;

      s_awid[0] = 6'd5; s_awaddr[0] = 32'h1000; s_awlen[0] = 8'd3; s_awsize[0] = 3'd3; s_awburst[0] = 2'd1;
      s_awvalid = 2'b01; m_awready = 1'b1;
      s_wvalid = 2'b01; s_wdata[0] = 64'h1;
      #1;
      check("wr_idle_awvalid", m_awvalid, 1'b0);
      check("wr_idle_wready", s_wready, 2'b00);
      tick();
      check("wr_addr_awvalid", m_awvalid, 1'b1);
      check("wr_addr_awaddr", m_awaddr, 32'h1000);
      check("wr_addr_awid", m_awid, 6'd5);
      check("wr_addr_awlen", m_awlen, 8'd3);
      check("wr_addr_awready", s_awready, 2'b01);
      check("wr_addr_holdoff", s_wready, 2'b00);
      tick();
      s_awvalid = 2'b00; m_wready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         s_wdata[0] = 64'(k);
         s_wlast[0] = (k == 4);
         #1;
         check("wr_beat_data", m_wdata, 64'(k));
         check("wr_beat_wready", s_wready, 2'b01);
         check("wr_beat_last", m_wlast, (k == 4));
         tick();
      end
      s_wvalid = 2'b00; s_wlast = 2'b00; m_wready = 1'b0;
      m_bvalid = 1'b1; m_bid = 6'd5; m_bresp = 2'b00; s_bready = 2'b01;
      #1;
      check("wr_b_route", s_bvalid, 2'b01);
      check("wr_b_id", s_bid[0], 6'd5);
      check("wr_b_bready", m_bready, 1'b1);
      tick();
      m_bvalid = 1'b0;
      #1;
      check("wr_b_done", s_bvalid, 2'b00);

      s_araddr[0] = 32'h2000; s_araddr[1] = 32'h3000; s_arlen = '0;
      m_arready = 1'b1; s_rready = 2'b11;
      s_arvalid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         e  = k % 2;
         oh = (e == 0) ? 2'b01 : 2'b10;
         #1;
         check("rd_idle_arvalid", m_arvalid, 1'b0);
         tick();
         check("rd_grant", s_arready, oh);
         check("rd_addr", m_araddr, (e == 0) ? 32'h2000 : 32'h3000);
         tick();
         s_arvalid[e] = 1'b0;
         m_rvalid = 1'b1; m_rlast = 1'b1; m_rdata = 64'hC0 + 64'(k);
         #1;
         check("rd_route", s_rvalid, oh);
         check("rd_data", s_rdata[e], 64'hC0 + 64'(k));
         tick();
         m_rvalid = 1'b0; m_rlast = 1'b0;
         if (k < 2) s_arvalid[e] = 1'b1;
      end
      s_arvalid = 2'b00;

      s_awid[1] = 6'h21; s_awaddr[1] = 32'h4000; s_awlen[1] = 8'd0; s_awvalid = 2'b10;
      s_arid[0] = 6'h12; s_araddr[0] = 32'h5000; s_arlen[0] = 8'd0; s_arvalid = 2'b01;
      m_awready = 1'b1; m_arready = 1'b1;
      tick();
      check("cc_awvalid", m_awvalid, 1'b1);
      check("cc_arvalid", m_arvalid, 1'b1);
      check("cc_awready", s_awready, 2'b10);
      check("cc_arready", s_arready, 2'b01);
      check("cc_awid", m_awid, 6'h21);
      check("cc_arid", m_arid, 6'h12);
      tick();
      s_awvalid = 2'b00; s_arvalid = 2'b00;
      s_wvalid = 2'b10; s_wdata[1] = 64'hDEAD; s_wlast[1] = 1'b1; m_wready = 1'b1;
      m_rvalid = 1'b1; m_rid = 6'h12; m_rdata = 64'hBEEF; m_rlast = 1'b1; s_rready = 2'b01;
      #1;
      check("cc_wready", s_wready, 2'b10);
      check("cc_wdata", m_wdata, 64'hDEAD);
      check("cc_rvalid", s_rvalid, 2'b01);
      check("cc_rdata", s_rdata[0], 64'hBEEF);
      check("cc_rid", s_rid[0], 6'h12);
      tick();
      s_wvalid = 2'b00; s_wlast = 2'b00; m_rvalid = 1'b0; m_rlast = 1'b0;
      m_bvalid = 1'b1; m_bid = 6'h21; s_bready = 2'b10;
      #1;
      check("cc_bvalid", s_bvalid, 2'b10);
      check("cc_bid", s_bid[1], 6'h21);
      tick();
      m_bvalid = 1'b0;

      s_awaddr[0] = 32'h8000; s_awlen[0] = 8'd3; s_awvalid = 2'b01;
      s_araddr[1] = 32'h9000; s_arlen[1] = 8'd3; s_arid[1] = 6'h7; s_arvalid = 2'b10;
      tick();
      tick();
      s_awvalid = 2'b00; s_arvalid = 2'b00;
      wi = 0; ri = 0; wn = 0; rn = 0; cyc = 0; stray = 1'b0;
      while ((wn < 4 || rn < 4) && cyc < 40) begin
         s_wvalid   = (wi < 4) ? 2'b01 : 2'b00;
         s_wdata[0] = 64'hA0 + 64'(wi);
         s_wlast[0] = (wi == 3);
         m_wready   = cyc[0];
         m_rvalid   = (ri < 4);
         m_rdata    = 64'hB0 + 64'(ri);
         m_rlast    = (ri == 3);
         m_rid      = 6'h7;
         s_rready   = (cyc >= 2 && cyc < 7) ? 2'b00 : 2'b10;
         #1;
         if (rn < 4) check("bp_rready_mirror", m_rready, s_rready[1]);
         stray = stray | s_rvalid[0] | s_wready[1];
         if (m_wvalid && m_wready && wn < 8) begin
            wgot[wn] = m_wdata;
            wn++;
         end
         if (s_wvalid[0] && s_wready[0]) wi++;
         if (s_rvalid[1] && s_rready[1] && rn < 8) begin
            rgot[rn] = s_rdata[1];
            rn++;
         end
         if (m_rvalid && m_rready) ri++;
         tick();
         cyc++;
      end
      s_wvalid = 2'b00; s_wlast = 2'b00; m_rvalid = 1'b0; m_rlast = 1'b0; m_wready = 1'b0;
      check("bp_timeout", (cyc < 40), 1'b1);
      check("bp_w_count", wn, 4);
      check("bp_r_count", rn, 4);
      check("bp_stray", stray, 1'b0);
      for (int k = 0; k < 4; k++) begin
         check("bp_w_data", wgot[k], 64'hA0 + 64'(k));
         check("bp_r_data", rgot[k], 64'hB0 + 64'(k));
      end
      m_bvalid = 1'b1; m_bid = 6'd0; s_bready = 2'b01;
      #1;
      check("bp_bvalid", s_bvalid, 2'b01);
      tick();
      m_bvalid = 1'b0;

      s_awaddr[0] = 32'hA000; s_awlen[0] = 8'd7; s_awvalid = 2'b01;
      tick();
      tick();
      s_awvalid = 2'b00; m_wready = 1'b1; s_wvalid = 2'b01;
      for (int k = 0; k < 2; k++) begin
         s_wdata[0] = 64'(k);
         tick();
      end
      s_wdata[0] = 64'h2;
      rst = 1'b1;
      tick();
      rst = 1'b0; s_wvalid = 2'b00;
      #1;
      check("mid_rst_wready", s_wready, 2'b00);
      check("mid_rst_awready", s_awready, 2'b00);
      check("mid_rst_arready", s_arready, 2'b00);
      check("mid_rst_bvalid", s_bvalid, 2'b00);
      check("mid_rst_rvalid", s_rvalid, 2'b00);
      check("mid_rst_wvalid", m_wvalid, 1'b0);
      s_awaddr[0] = 32'h6000; s_awaddr[1] = 32'h7000; s_awlen = '0; s_awvalid = 2'b11;
      #1;
      check("post_rst_idle", m_awvalid, 1'b0);
      tick();
      check("post_rst_grant", s_awready, 2'b01);
      check("post_rst_addr", m_awaddr, 32'h6000);
      s_awvalid = 2'b00;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;

`ifdef AXI_MEM_ARB_PERF_EN
      for (int k = 0; k < 3; k++) single_write(0);
      for (int k = 0; k < 2; k++) single_read(1);
      check("perf_wr0", o_wr_bursts[0], 32'd3);
      check("perf_wr1", o_wr_bursts[1], 32'd0);
      check("perf_rd0", o_rd_bursts[0], 32'd0);
      check("perf_rd1", o_rd_bursts[1], 32'd2);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi_mem_arbiter.md
Name: axi_mem_arbiter

Overview:
- Two-master to one-slave AXI4 arbiter that shares the single DDR memory port between the CPU AXI master (port 0) and a second master (port 1, e.g. DMA or a verification-platform agent).
- Sits in the clk_core domain, upstream of the clock-domain crossing into the DDR controller.
- Read and write channels arbitrate independently, each round-robin.
- At most one outstanding burst per direction, so IDs pass through unmodified.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 64, data width; strobe width is DATA_W/8
- ID_W, 6, AXI ID width

Ports:
- clk  in  1  clock (clk_core)
- rst  in  1  synchronous active-high reset
- s_aw{id,addr,len,size,burst,valid}  in  [1:0][ID_W/ADDR_W/8/3/2/1]  AW request, per master
- s_awready  out  [1:0]  AW accept, per master
- s_w{data,strb,last,valid}  in  [1:0][DATA_W/DATA_W/8/1/1]  write data, per master
- s_wready  out  [1:0]  write data accept
- s_b{id,resp,valid}  out  [1:0][ID_W/2/1]  write response, per master
- s_bready  in  [1:0]  response accept
- s_ar{id,addr,len,size,burst,valid}  in  [1:0][as AW]  read request
- s_arready  out  [1:0]  read request accept
- s_r{id,data,resp,last,valid}  out  [1:0][ID_W/DATA_W/2/1/1]  read data
- s_rready  in  [1:0]  read data accept
- m_*  mirror of one s_* port, opposite direction, no [1:0] dimension; connects to the memory AXI bus

Behaviour:
- Reset (synchronous, rst=1 at posedge clk):
  - both FSMs go to IDLE; both round-robin pointers set to "last=1", so master 0 wins first.
  - All valid/ready outputs read 0; m_aw*/m_ar*/m_w* payloads read 0.
  - Reset mid-burst abandons the transfer; no completion is generated.
- Write FSM states, WR_IDLE -> WR_ADDR -> WR_DATA -> WR_RESP -> WR_IDLE:
  - WR_IDLE: if any s_awvalid, register winner wsel; go to WR_ADDR next cycle (1-cycle arbitration latency). No readies asserted.
  - WR_ADDR: m_aw* = s_aw*[wsel]; s_awready[wsel] = m_awready. On m_awvalid&&m_awready go to WR_DATA.
  - WR_DATA: m_w* = s_w*[wsel]; s_wready[wsel] = m_wready. On handshake with wlast=1 go to WR_RESP.
  - WR_RESP: s_b*[wsel] = m_b*; m_bready = s_bready[wsel]. On handshake update last_w=wsel; go to WR_IDLE.
- Read FSM states, RD_IDLE -> RD_ADDR -> RD_DATA -> RD_IDLE:
  - Same pattern as write. R beats routed to rsel.
  - Exit RD_DATA on handshake with rlast=1; update last_r=rsel.
- Round-robin rule:
  - Only one valid: that master wins.
  - Both valid: the master != last wins.
- Non-granted master: every ready and every valid it sees is 0.
- Combinational paths: only ready/valid muxing by registered wsel/rsel; no payload registering. Latency through the arbiter is 0 cycles once in an ADDR/DATA/RESP state.
- Write data arriving before AW is held off (wready=0) until WR_DATA. Masters must not make AW wait on W.
- Read and write FSMs are fully independent. Simultaneous AR and AW from any masters proceed in parallel.
- A new burst is granted only from IDLE. Minimum gap between consecutive bursts in one direction is 1 idle cycle.
- len=0 (single beat): wlast/rlast on first beat; DATA exits after one handshake.

Optional Feature:
- Macro: AXI_MEM_ARB_PERF_EN.
- Defined:
  - Adds outputs o_wr_bursts [1:0][31:0] and o_rd_bursts [1:0][31:0].
  - Each counter increments by 1 on its master's B handshake (write) or final R handshake (read).
  - Counters wrap at 2^32 and clear on rst.
- Undefined: ports and counters are absent; no other behavioural change.

Decomposition:
- Package axi_mem_arb_pkg holds:
  - wr_state_t enum (WR_IDLE, WR_ADDR, WR_DATA, WR_RESP)
  - rd_state_t enum (RD_IDLE, RD_ADDR, RD_DATA)
  - localparam NUM_MST=2
- Sub-module axi_arb_rr2 is the 2-way round-robin picker:
  - Inputs: req[1:0], last.
  - Output: gnt index.
  - Instantiated once for write and once for read.

Test Plan:
- Reset, then s_awvalid[0] only, len=3 → m_awvalid one cycle after WR_IDLE. Four W beats pass through with data 0x1..0x4. Response goes to s_bvalid[0] only; s_bvalid[1]=0 throughout.
- Both s_arvalid asserted in the same cycle after reset → master 0 granted first. After its rlast handshake, master 1 granted next. Repeat twice → grants alternate 0,1,0,1.
- Concurrent write from master 1 and read from master 0 → both m_awvalid and m_arvalid asserted in the same cycle. Both bursts complete without interleaving into the wrong master.
- Backpressure: m_wready toggles every cycle, and s_rready[1] held 0 for 5 cycles mid-burst → no beat lost or duplicated; m_rready mirrors s_rready[1].
- rst asserted during WR_DATA beat 2 of 8 → next cycle all s_*ready/s_*valid outputs are 0 and the FSM is in WR_IDLE. A new AW from master 0 is then granted normally.
- With AXI_MEM_ARB_PERF_EN defined: 3 writes from master 0 and 2 reads from master 1 → o_wr_bursts[0]=3, o_rd_bursts[1]=2, others 0.
